// File: rtl/cla_16bit_pkg.sv
// cla_16bit_pkg
// Shared constants for the 16-bit two-level carry-lookahead adder.
//   ADDER_W : operand width of the full adder
//   GROUP_W : width of one first-level lookahead group
package cla_16bit_pkg;

    localparam int ADDER_W = 16;
    localparam int GROUP_W = 4;

endpackage : cla_16bit_pkg

// File: rtl/cla_4bit.sv
// cla_4bit
// First-level 4-bit carry-lookahead group. Computes the sum bits from the
// group carry-in and exports group propagate/generate so that a second-level
// unit can produce the group carry-ins without rippling through this group.
// Ports:
//   a, b : 4-bit operand slices
//   cin  : carry into bit 0 of the group
//   s    : 4-bit sum slice
//   pg   : group propagate (all four bits propagate)
//   gg   : group generate (group produces a carry-out on its own)
module cla_4bit
    import cla_16bit_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               pg,
    output logic               gg
);

    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every internal carry is a flat sum of products of g/p and cin, so no
    // carry depends on a previous carry output.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & cin);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign s  = w_p ^ w_c;

    assign pg = w_p[3] & w_p[2] & w_p[1] & w_p[0];
    assign gg = w_g[3]
              | (w_p[3] & w_g[2])
              | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule : cla_4bit

// File: rtl/cla_16bit.sv
// cla_16bit
// 16-bit two-level carry-lookahead adder with registered outputs.
// Four cla_4bit groups feed a second-level lookahead unit that forms the
// group carry-ins c4/c8/c12 and the carry-out c16 directly from the group
// PG/GG terms and Cin. The sum and carry-out are flopped, giving a fixed
// one-cycle latency and one new operation per cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears S and Cout
//   A, B : 16-bit unsigned addends
//   Cin  : carry into bit 0
//   S    : registered sum bits [15:0] of A+B+Cin
//   Cout : registered carry-out (bit 16 of A+B+Cin)
module cla_16bit
    import cla_16bit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDER_W-1:0] A,
    input  logic [ADDER_W-1:0] B,
    input  logic               Cin,
    output logic [ADDER_W-1:0] S,
    output logic               Cout
);

    localparam int N_GROUPS = ADDER_W / GROUP_W;

    logic [N_GROUPS-1:0] w_pg;
    logic [N_GROUPS-1:0] w_gg;
    // w_gc[k] is the carry into group k; w_gc[N_GROUPS] is the carry-out.
    logic [N_GROUPS:0]   w_gc;
    logic [ADDER_W-1:0]  w_sum;

    logic [ADDER_W-1:0]  r_sum;
    logic                r_cout;

    genvar gi;
    generate
        for (gi = 0; gi < N_GROUPS; gi++) begin : g_grp
            cla_4bit u_grp (
                .a   (A[gi*GROUP_W +: GROUP_W]),
                .b   (B[gi*GROUP_W +: GROUP_W]),
                .cin (w_gc[gi]),
                .s   (w_sum[gi*GROUP_W +: GROUP_W]),
                .pg  (w_pg[gi]),
                .gg  (w_gg[gi])
            );
        end
    endgenerate

    // Second-level lookahead: same recurrence as inside a group, but on
    // group PG/GG, so c16 never waits on the lower groups' sum logic.
    assign w_gc[0] = Cin;
    assign w_gc[1] = w_gg[0]
                   | (w_pg[0] & Cin);
    assign w_gc[2] = w_gg[1]
                   | (w_pg[1] & w_gg[0])
                   | (w_pg[1] & w_pg[0] & Cin);
    assign w_gc[3] = w_gg[2]
                   | (w_pg[2] & w_gg[1])
                   | (w_pg[2] & w_pg[1] & w_gg[0])
                   | (w_pg[2] & w_pg[1] & w_pg[0] & Cin);
    assign w_gc[4] = w_gg[3]
                   | (w_pg[3] & w_gg[2])
                   | (w_pg[3] & w_pg[2] & w_gg[1])
                   | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
                   | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & Cin);

    // Output register; reset wins over the adder result at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= 16'h0000;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_gc[N_GROUPS];
        end
    end

    assign S    = r_sum;
    assign Cout = r_cout;

endmodule : cla_16bit

// File: tb/tb_cla_16bit.sv
// tb_cla_16bit
// Self-checking bench for cla_16bit: directed vectors with hand-computed
// results, a reset sequence, a mid-stream reset, a randomised sweep checked
// against a 17-bit reference sum, and a back-to-back stream.
module tb_cla_16bit;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [15:0] S;
    logic        Cout;

    int n_total;
    int n_pass;
    int n_fail;

    cla_16bit dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] exp_v);
        logic [16:0] obs_v;
        obs_v   = {Cout, S};
        n_total = n_total + 1;
        assert (obs_v === exp_v) begin
            n_pass = n_pass + 1;
        end else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed={Cout,S}=%05h expected=%05h", tag, obs_v, exp_v);
        end
    endtask

    // Drive operands, let one rising edge pass, then sample 1 time unit later.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic c);
        A   = a;
        B   = b;
        Cin = c;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [15:0] ra;
        logic [15:0] rb;
        logic [16:0] ref_v;
        logic [15:0] qa [0:7];
        logic [15:0] qb [0:7];
        logic        qc [0:7];
        int          rand_fail_base;

        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;

        // Reset held for two edges with live operands on the inputs.
        rst = 1'b1;
        A   = 16'h1234;
        B   = 16'h1111;
        Cin = 1'b1;
        @(posedge clk);
        #1;
        check("reset_cycle1", 17'h0_0000);
        @(posedge clk);
        #1;
        check("reset_cycle2", 17'h0_0000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_reset", 17'h0_2346);

        // Directed vectors.
        apply(16'h0000, 16'h0000, 1'b0); check("zero", 17'h0_0000);
        apply(16'h1234, 16'h4321, 1'b0); check("no_carry", 17'h0_5555);
        apply(16'h00FF, 16'h0001, 1'b0); check("low_group_carry", 17'h0_0100);
        apply(16'hFFFF, 16'h0000, 1'b1); check("ffff_plus_cin", 17'h1_0000);
        apply(16'hFFFF, 16'h0001, 1'b0); check("full_propagate", 17'h1_0000);
        apply(16'hFFFF, 16'hFFFF, 1'b1); check("max_cin1", 17'h1_FFFF);
        apply(16'hFFFF, 16'hFFFF, 1'b0); check("max_cin0", 17'h1_FFFE);
        apply(16'h8000, 16'h8000, 1'b0); check("msb_carry", 17'h1_0000);
        apply(16'h0F0F, 16'hF0F0, 1'b1); check("group_boundary", 17'h1_0000);
        apply(16'h0FFF, 16'h0001, 1'b0); check("three_group_ripple", 17'h0_1000);
        apply(16'hAAAA, 16'h5555, 1'b0); check("alt_bits", 17'h0_FFFF);

        // Output must hold across the cycle until the next edge.
        #3;
        check("hold_until_edge", 17'h0_FFFF);

        // Mid-stream reset discards the pending result.
        rst = 1'b1;
        apply(16'h7FFF, 16'h0001, 1'b0); check("midstream_reset", 17'h0_0000);
        rst = 1'b0;
        apply(16'h7FFF, 16'h0001, 1'b0); check("after_mid_reset", 17'h0_8000);

        // Randomised sweep: each pair with Cin=0 then Cin=1.
        rand_fail_base = n_fail;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            for (int c = 0; c < 2; c++) begin
                ref_v = {1'b0, ra} + {1'b0, rb} + {16'h0000, (c == 1)};
                apply(ra, rb, (c == 1));
                check("random", ref_v);
            end
        end
        if (n_fail != rand_fail_base) begin
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end

        // Back-to-back stream: new operands every cycle, each result checked
        // on the cycle right after its inputs.
        qa[0] = 16'h0001; qb[0] = 16'h0001; qc[0] = 1'b0;
        qa[1] = 16'h0002; qb[1] = 16'h0002; qc[1] = 1'b1;
        qa[2] = 16'hFFFF; qb[2] = 16'h0000; qc[2] = 1'b1;
        qa[3] = 16'h1000; qb[3] = 16'h2000; qc[3] = 1'b0;
        qa[4] = 16'h0003; qb[4] = 16'h0004; qc[4] = 1'b0;
        qa[5] = 16'hC000; qb[5] = 16'h4000; qc[5] = 1'b1;
        qa[6] = 16'h0003; qb[6] = 16'h0004; qc[6] = 1'b0;
        qa[7] = 16'h00F0; qb[7] = 16'h0010; qc[7] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ref_v = {1'b0, qa[k]} + {1'b0, qb[k]} + {16'h0000, qc[k]};
            apply(qa[k], qb[k], qc[k]);
            check("back_to_back", ref_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule : tb_cla_16bit
